// File: rtl/apb_soc_ctrl.sv
// apb_soc_ctrl: APB3 SoC control block with pad mux/config, boot address, lock and clock-gate handshake
module apb_soc_ctrl #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter logic [31:0] BOOT_ADDR      = 32'h8000,
    parameter int          NUM_PADS       = 32,
    parameter int          PADCFG_W       = 6,
    parameter int          NUM_CG         = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]    PADDR,
    input  logic [31:0]                  PWDATA,
    input  logic                         PWRITE,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    output logic [31:0]                  PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [NUM_PADS-1:0]          pad_mux_o,
    output logic [NUM_PADS*PADCFG_W-1:0] pad_cfg_o,
    output logic [31:0]                  boot_addr_o,
    output logic [NUM_CG-1:0]            cg_en_o,
    output logic                         cg_req_o,
    input  logic                         cg_ack_i
);
    localparam logic [31:0] INFO = {8'(NUM_PADS), 8'(NUM_CG), 8'(PADCFG_W), 8'h02};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

    state_t             state, state_d;
    logic [5:0]         word;
    logic               is_mux, is_cg, is_boot, is_lock, is_info, is_pcfg, mapped;
    logic               busy, access, err, commit;
    logic               wr_mux, wr_cg, wr_boot, wr_lock, wr_pcfg;
    logic               lock;
    logic [NUM_CG-1:0]  pending;
    logic [31:0]        pcfg_rd, rdata;
    logic               unused_bits;

    assign word    = PADDR[7:2];
    assign is_mux  = word == 6'h00;
    assign is_cg   = word == 6'h01;
    assign is_boot = word == 6'h02;
    assign is_lock = word == 6'h03;
    assign is_info = word == 6'h04;
    assign is_pcfg = word[5:4] == 2'b01 && word[3:0] < 4'(NUM_PADS/4);
    assign mapped  = is_mux | is_cg | is_boot | is_lock | is_info | is_pcfg;
    assign busy    = state != S_IDLE;
    assign access  = PSEL & PENABLE;
    assign err     = !mapped | (PWRITE & is_info) | (PWRITE & lock & (is_mux | is_boot | is_pcfg));

    // A clock-gate write stalls until the previous handshake is fully released
    assign PREADY  = !HRESETn | !(PSEL & PWRITE & is_cg & busy);
    assign PSLVERR = HRESETn & access & PREADY & err;
    assign commit  = access & PWRITE & PREADY & !err;
    assign wr_mux  = commit & is_mux;
    assign wr_cg   = commit & is_cg;
    assign wr_boot = commit & is_boot;
    assign wr_lock = commit & is_lock;
    assign wr_pcfg = commit & is_pcfg;

    assign cg_req_o    = state == S_REQ;
    assign unused_bits = ^{PADDR, PWDATA};

    // Gather the four pad configs of the addressed PADCFG word into byte lanes
    always_comb begin
        pcfg_rd = '0;
        for (int p = 0; p < NUM_PADS; p++)
            if (4'(p/4) == word[3:0]) pcfg_rd[8*(p%4) +: PADCFG_W] = pad_cfg_o[p*PADCFG_W +: PADCFG_W];
    end

    assign rdata  = is_mux  ? 32'(pad_mux_o)
                  : is_cg   ? {busy, 31'(cg_en_o)}
                  : is_boot ? boot_addr_o
                  : is_lock ? {31'b0, lock}
                  : is_info ? INFO
                  : is_pcfg ? pcfg_rd
                  : '0;
    assign PRDATA = (access & !PWRITE) ? rdata : '0;

    // Handshake state register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_d;
    end

    // Handshake next state: request until ack, then wait for ack release
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (wr_cg)     state_d = S_REQ;
            S_REQ:   if (cg_ack_i)  state_d = S_REL;
            S_REL:   if (!cg_ack_i) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Configuration registers; enables are applied only when the controller acks
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pad_mux_o   <= '0;
            pad_cfg_o   <= '0;
            boot_addr_o <= BOOT_ADDR;
            lock        <= 1'b0;
            cg_en_o     <= '0;
            pending     <= '0;
        end else begin
            if (wr_mux) pad_mux_o <= PWDATA[NUM_PADS-1:0];
            if (wr_boot) boot_addr_o <= PWDATA;
            if (wr_lock & PWDATA[0]) lock <= 1'b1;
            if (wr_cg & !busy) pending <= PWDATA[NUM_CG-1:0];
            if (cg_req_o & cg_ack_i) cg_en_o <= pending;
            for (int p = 0; p < NUM_PADS; p++)
                if (wr_pcfg && 4'(p/4) == word[3:0])
                    pad_cfg_o[p*PADCFG_W +: PADCFG_W] <= PWDATA[8*(p%4) +: PADCFG_W];
        end
    end
endmodule

// File: doc/apb_soc_ctrl.md
APB_SOC_CTRL -- requirements
Module: apb_soc_ctrl

Interface
- REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12: APB address width; only PADDR[7:2] is decoded.
- REQ-002 SHALL have parameter BOOT_ADDR, default 32'h8000: boot address reset value.
- REQ-003 SHALL have parameter NUM_PADS, default 32: pad count; legal values are multiples of 4 in the range 4..32.
- REQ-004 SHALL have parameter PADCFG_W, default 6: config bits per pad; legal range 1..8.
- REQ-005 SHALL have parameter NUM_CG, default 8: clock-gate channels; legal range 1..31.
- REQ-006 SHALL have port HCLK, in, 1: the single clock; all state changes on its rising edge.
- REQ-007 SHALL have port HRESETn, in, 1: reset, synchronous and active-low.
- REQ-008 SHALL have ports PADDR [APB_ADDR_WIDTH], PWDATA [32], PWRITE, PSEL, PENABLE, all inputs: APB3 request.
- REQ-009 SHALL have ports PRDATA [32], PREADY [1], PSLVERR [1], all outputs: APB3 response.
- REQ-010 SHALL have port pad_mux_o, out, NUM_PADS: per-pad mux select.
- REQ-011 SHALL have port pad_cfg_o, out, NUM_PADS*PADCFG_W: pad k occupies bits [k*PADCFG_W +: PADCFG_W].
- REQ-012 SHALL have port boot_addr_o, out, 32: boot address.
- REQ-013 SHALL have port cg_en_o, out, NUM_CG: applied clock enables.
- REQ-014 SHALL have port cg_req_o, out, 1: clock-gate change request (4-phase handshake).
- REQ-015 SHALL have port cg_ack_i, in, 1: clock-controller acknowledge.

Function
- REQ-016 SHALL decode word offsets as follows:
  - 0x00: PAD_MUX, RW, bits [NUM_PADS-1:0].
  - 0x04: CLK_GATE; write sets bits [NUM_CG-1:0]; read returns {busy, 0, cg_en_o}, busy at bit 31.
  - 0x08: BOOT_ADR, RW.
  - 0x0C: LOCK, RW; bit0 only.
  - 0x10: INFO, RO = {NUM_PADS[7:0], NUM_CG[7:0], PADCFG_W[7:0], 8'h02}.
  - 0x40+4k, k=0..NUM_PADS/4-1: PADCFG k; byte j, bits [PADCFG_W-1:0], holds the config of pad 4k+j.
- REQ-017 SHALL commit a write only in a cycle with PSEL & PENABLE & PWRITE & PREADY; unused PWDATA bits are ignored; unimplemented bits read 0.
- REQ-018 SHALL drive PRDATA to the register value when PSEL & PENABLE & !PWRITE, and to 0 otherwise.
- REQ-019 SHALL drive PREADY=1 for every access except a CLK_GATE write while the handshake FSM is not IDLE, which holds PREADY=0 until the FSM reaches IDLE.
- REQ-020 SHALL assert PSLVERR=1 only in the completing access cycle (PSEL & PENABLE & PREADY), for any of:
  - an unmapped offset, read or write;
  - a write to INFO;
  - a write to PAD_MUX, BOOT_ADR or PADCFG while LOCK=1.
- REQ-021 SHALL leave all state unchanged on an errored access, and SHALL read 0 from unmapped offsets.
- REQ-022 SHALL set LOCK by writing 1 to bit0; LOCK SHALL be sticky, writing 0 has no effect, and only reset clears it; writing LOCK when already locked is not an error.
- REQ-023 SHALL keep CLK_GATE writable while locked.
- REQ-024 SHALL implement the handshake FSM with states IDLE, REQ, REL:
  - IDLE + committed CLK_GATE write: latch pending = PWDATA[NUM_CG-1:0]; go to REQ.
  - REQ: cg_req_o=1; on cg_ack_i=1, load cg_en_o from pending and go to REL.
  - REL: cg_req_o=0; on cg_ack_i=0, go to IDLE.
- REQ-025 SHALL assert cg_req_o in the cycle after the write commits; busy = (state != IDLE).
- REQ-026 SHALL perform the full handshake even when the written value equals cg_en_o.
- REQ-027 SHALL ignore cg_ack_i while IDLE.
- REQ-028 SHALL drive outputs directly from registers, with no combinational path from APB inputs to pad_*, boot_addr_o, cg_en_o or cg_req_o.

Reset
- REQ-029 SHALL, when HRESETn=0 at a rising HCLK edge, set:
  - pad_mux_o = 0, pad_cfg_o = 0, LOCK = 0;
  - boot_addr_o = BOOT_ADDR;
  - cg_en_o = 0, pending = 0;
  - FSM = IDLE, cg_req_o = 0.
- REQ-030 SHALL abort any in-flight handshake on reset, including one in REQ or REL.
- REQ-031 SHALL keep PREADY=1 and PSLVERR=0 while in reset.

Verification
- REQ-032 SHALL verify PADCFG: NUM_PADS=32, PADCFG_W=6; write 0x44 = 0x3F2A1505 -> pads 4..7 cfg = 0x05, 0x15, 0x2A, 0x3F; read 0x44 = 0x3F2A1505.
- REQ-033 SHALL verify the handshake: write CLK_GATE = 0xA5 -> cg_req_o=1 next cycle; cg_en_o stays 0 until ack; ack high -> cg_en_o = 0xA5 and req=0; ack low -> IDLE; read 0x04 = 0x000000A5.
- REQ-034 SHALL verify back-to-back writes: write 0x0F during REQ -> PREADY=0 until IDLE, then commit; the second handshake yields cg_en_o = 0x0F.
- REQ-035 SHALL verify LOCK: write LOCK = 1, then BOOT_ADR = 0x1234 -> PSLVERR=1 and boot_addr_o stays 0x8000; CLK_GATE write still succeeds; write LOCK = 0 -> LOCK remains 1.
- REQ-036 SHALL verify errors: read 0x20 -> PRDATA = 0, PSLVERR=1; write INFO -> PSLVERR=1; read INFO with defaults -> 0x20080602.
- REQ-037 SHALL verify reset mid-handshake: HRESETn=0 while in REQ -> cg_req_o=0, cg_en_o=0, FSM IDLE, LOCK=0 after the edge.
